// File: rtl/input_cond_pkg.sv
// Shared state encoding and default parameters for the push-button/switch
// input conditioner and its debounce channels.
package input_cond_pkg;

  localparam int SYNC_STAGES_DEF     = 2;
  localparam int DEBOUNCE_CYCLES_DEF = 16;
  localparam int REPEAT_CYCLES_DEF   = 8;

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'b00,
    WAIT_HIGH = 2'b01,
    IDLE_HIGH = 2'b10,
    WAIT_LOW  = 2'b11
  } deb_state_t;

  // Counter width able to hold 0..n without wrapping.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One conditioned input: synchronizer chain followed by a 4-state debounce FSM
// that accepts a level change only after DEBOUNCE_CYCLES consecutive samples.
module debounce_channel
  import input_cond_pkg::*;
#(
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic i_raw,
  output logic o_level,
  output logic o_rise_next,
  output logic o_fall_next
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]       r_cnt;
  deb_state_t             r_state;
  logic                   r_level;
  logic                   w_sync;
  logic                   w_done;

  assign w_sync = r_sync[SYNC_STAGES-1];
  // The sample on this edge is the DEBOUNCE_CYCLES-th consecutive one.
  assign w_done = (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

  // Combinational look-ahead so the top can register a pulse that lines up
  // with the cycle the level actually changes.
  assign o_rise_next = (r_state == WAIT_HIGH) && w_sync && w_done;
  assign o_fall_next = (r_state == WAIT_LOW) && !w_sync && w_done;
  assign o_level     = r_level;

  // NOTE: all state here updates with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync  <= '0;
      r_cnt   <= '0;
      r_state <= IDLE_LOW;
      r_level <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
      case (r_state)
        IDLE_LOW: begin
          if (w_sync) begin
            r_state <= WAIT_HIGH;
            r_cnt   <= CNT_W'(1);
          end
        end
        WAIT_HIGH: begin
          if (!w_sync) begin
            r_state <= IDLE_LOW;
            r_cnt   <= '0;
          end else if (w_done) begin
            r_state <= IDLE_HIGH;
            r_level <= 1'b1;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        IDLE_HIGH: begin
          if (!w_sync) begin
            r_state <= WAIT_LOW;
            r_cnt   <= CNT_W'(1);
          end
        end
        WAIT_LOW: begin
          if (w_sync) begin
            r_state <= IDLE_HIGH;
            r_cnt   <= '0;
          end else if (w_done) begin
            r_state <= IDLE_LOW;
            r_level <= 1'b0;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/input_conditioner.sv
// Button and switch front end for the accumulator FSM: debounced levels plus a
// registered one-cycle next_pulse per accepted press. Optional auto-repeat
// while the button is held is enabled by INPUT_CONDITIONER_AUTOREPEAT_EN.
module input_conditioner
  import input_cond_pkg::*;
#(
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int REPEAT_CYCLES   = REPEAT_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  input  logic sw_raw,
  output logic btn_level,
  output logic in_level,
  output logic next_pulse
);

  logic w_btn_rise_next;
  logic w_btn_fall_next;
  logic w_sw_rise_unused;
  logic w_sw_fall_unused;
  logic w_rep_fire;
  logic r_next_pulse;

  debounce_channel #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn (
    .clk        (clk),
    .reset      (reset),
    .i_raw      (btn_raw),
    .o_level    (btn_level),
    .o_rise_next(w_btn_rise_next),
    .o_fall_next(w_btn_fall_next)
  );

  debounce_channel #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_sw (
    .clk        (clk),
    .reset      (reset),
    .i_raw      (sw_raw),
    .o_level    (in_level),
    .o_rise_next(w_sw_rise_unused),
    .o_fall_next(w_sw_fall_unused)
  );

`ifdef INPUT_CONDITIONER_AUTOREPEAT_EN
  localparam int REP_W = cnt_width(REPEAT_CYCLES);

  logic [REP_W-1:0] r_rep_cnt;

  // Suppressed on the edge the level falls so a release never pulses.
  assign w_rep_fire = btn_level && !w_btn_fall_next &&
                      (r_rep_cnt == REP_W'(REPEAT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset || !btn_level || w_rep_fire) begin
      r_rep_cnt <= '0;
    end else begin
      r_rep_cnt <= r_rep_cnt + REP_W'(1);
    end
  end
`else
  localparam int unused_repeat_cycles = REPEAT_CYCLES;
  logic w_fall_unused;

  assign w_rep_fire    = 1'b0;
  assign w_fall_unused = w_btn_fall_next;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_next_pulse <= 1'b0;
    end else begin
      r_next_pulse <= w_btn_rise_next | w_rep_fire;
    end
  end

  assign next_pulse = r_next_pulse;

endmodule
